// File: rtl/hazard_controller.sv
// Execute-stage hazard sequencer: operand forwarding, load-use bubbles, redirect flushes,
// multi-cycle EX handshake with watchdog, and a saturating front-end stall counter.
module hazard_controller #(
    parameter int unsigned MC_TIMEOUT  = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_uses_rs1_i,
    input  logic                   id_uses_rs2_i,
    input  logic [4:0]             ex_rs1_i,
    input  logic [4:0]             ex_rs2_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   ex_write_reg_i,
    input  logic                   ex_use_mem_i,
    input  logic                   ex_is_multicycle_i,
    input  logic                   ex_trap_i,
    input  logic                   pc_load_target_i,
    input  logic [4:0]             mem_rd_i,
    input  logic                   mem_write_reg_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   wb_write_reg_i,
    input  logic                   mc_done_i,
    output logic                   use_EX_MEM_rs1_o,
    output logic                   use_EX_MEM_rs2_o,
    output logic                   use_MEM_WB_rs1_o,
    output logic                   use_MEM_WB_rs2_o,
    output logic                   stall_IF_o,
    output logic                   stall_ID_o,
    output logic                   stall_EX_o,
    output logic                   flush_IF_ID_o,
    output logic                   flush_ID_EX_o,
    output logic                   flush_EX_MEM_o,
    output logic                   mc_start_o,
    output logic                   mc_abort_o,
    output logic                   mc_timeout_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    localparam int unsigned    CNT_W    = $clog2(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_set;

    logic fwd_mem_rs1;
    logic fwd_mem_rs2;
    logic load_use;
    logic redirect;

    assign fwd_mem_rs1 = mem_write_reg_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs1_i);
    assign fwd_mem_rs2 = mem_write_reg_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs2_i);
    assign load_use    = ex_use_mem_i && ex_write_reg_i && (ex_rd_i != 5'd0) &&
                         ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                          (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    assign redirect    = ex_trap_i || pc_load_target_i;

    // Next state and all pipeline controls; everything is forced low while reset is held.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        timeout_set      = 1'b0;
        use_EX_MEM_rs1_o = 1'b0;
        use_EX_MEM_rs2_o = 1'b0;
        use_MEM_WB_rs1_o = 1'b0;
        use_MEM_WB_rs2_o = 1'b0;
        stall_IF_o       = 1'b0;
        stall_ID_o       = 1'b0;
        stall_EX_o       = 1'b0;
        flush_IF_ID_o    = 1'b0;
        flush_ID_EX_o    = 1'b0;
        flush_EX_MEM_o   = 1'b0;
        mc_start_o       = 1'b0;
        mc_abort_o       = 1'b0;

        if (!reset) begin
            use_EX_MEM_rs1_o = fwd_mem_rs1;
            use_EX_MEM_rs2_o = fwd_mem_rs2;
            use_MEM_WB_rs1_o = wb_write_reg_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs1_i) && !fwd_mem_rs1;
            use_MEM_WB_rs2_o = wb_write_reg_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs2_i) && !fwd_mem_rs2;

            case (state)
                IDLE: begin
                    if (!redirect && ex_is_multicycle_i) begin
                        mc_start_o     = 1'b1;
                        stall_IF_o     = 1'b1;
                        stall_ID_o     = 1'b1;
                        stall_EX_o     = 1'b1;
                        flush_EX_MEM_o = 1'b1;
                        state_nxt      = BUSY;
                        cnt_nxt        = '0;
                    end else if (!redirect && load_use) begin
                        stall_IF_o    = 1'b1;
                        stall_ID_o    = 1'b1;
                        flush_ID_EX_o = 1'b1;
                    end
                end
                BUSY: begin
                    if (ex_trap_i) begin
                        mc_abort_o = 1'b1;
                        state_nxt  = IDLE;
                    end else if (mc_done_i) begin
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        mc_abort_o     = 1'b1;
                        flush_EX_MEM_o = 1'b1;
                        timeout_set    = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        stall_IF_o     = 1'b1;
                        stall_ID_o     = 1'b1;
                        stall_EX_o     = 1'b1;
                        flush_EX_MEM_o = 1'b1;
                        cnt_nxt        = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // A redirect must load the PC and bubble IF/ID, ID/EX, so it beats every stall.
            if (redirect) begin
                flush_IF_ID_o = 1'b1;
                flush_ID_EX_o = 1'b1;
                stall_IF_o    = 1'b0;
                stall_ID_o    = 1'b0;
                stall_EX_o    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mc_timeout_o  <= 1'b0;
            stall_count_o <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) begin
                mc_timeout_o <= 1'b1;
            end
            if (stall_IF_o && (stall_count_o != '1)) begin
                stall_count_o <= stall_count_o + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against a cycle-level reference model.
module tb_hazard_controller;

    localparam int unsigned MC_TIMEOUT  = 8;
    localparam int unsigned STALL_CNT_W = 5;
    localparam int          SAT         = (1 << STALL_CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_write_reg, ex_use_mem, ex_is_mc, ex_trap, pc_load;
    logic mem_write_reg, wb_write_reg, mc_done;
    logic use_ex_mem_rs1, use_ex_mem_rs2, use_mem_wb_rs1, use_mem_wb_rs2;
    logic stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic mc_start, mc_abort, mc_timeout;
    logic [STALL_CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_busy;
    int m_cycles;   // BUSY cycles already spent
    bit m_to;
    int m_stalls;
    bit n_busy, n_to;
    int n_cycles;
    bit e_fm1, e_fm2, e_fw1, e_fw2, e_sif, e_sid, e_sex, e_fifid, e_fidex, e_fexmem, e_start, e_abort;

    always #5 clk = ~clk;

    hazard_controller #(.MC_TIMEOUT(MC_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_write_reg_i(ex_write_reg),
        .ex_use_mem_i(ex_use_mem), .ex_is_multicycle_i(ex_is_mc), .ex_trap_i(ex_trap),
        .pc_load_target_i(pc_load), .mem_rd_i(mem_rd), .mem_write_reg_i(mem_write_reg),
        .wb_rd_i(wb_rd), .wb_write_reg_i(wb_write_reg), .mc_done_i(mc_done),
        .use_EX_MEM_rs1_o(use_ex_mem_rs1), .use_EX_MEM_rs2_o(use_ex_mem_rs2),
        .use_MEM_WB_rs1_o(use_mem_wb_rs1), .use_MEM_WB_rs2_o(use_mem_wb_rs2),
        .stall_IF_o(stall_if), .stall_ID_o(stall_id), .stall_EX_o(stall_ex),
        .flush_IF_ID_o(flush_if_id), .flush_ID_EX_o(flush_id_ex), .flush_EX_MEM_o(flush_ex_mem),
        .mc_start_o(mc_start), .mc_abort_o(mc_abort), .mc_timeout_o(mc_timeout),
        .stall_count_o(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_write_reg, ex_use_mem, ex_is_mc, ex_trap, pc_load} = '0;
        {mem_write_reg, wb_write_reg, mc_done} = '0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_cycles = 0; m_to = 0; m_stalls = 0;
    endtask

    // Expected outputs for the current inputs, plus the model's next state.
    task automatic model_eval();
        bit hit1, hit2, lu, redir, expired;
        e_fm1 = mem_write_reg && mem_rd != 0 && mem_rd == ex_rs1;
        e_fm2 = mem_write_reg && mem_rd != 0 && mem_rd == ex_rs2;
        e_fw1 = wb_write_reg && wb_rd != 0 && wb_rd == ex_rs1 && !e_fm1;
        e_fw2 = wb_write_reg && wb_rd != 0 && wb_rd == ex_rs2 && !e_fm2;
        hit1  = id_uses_rs1 && id_rs1 == ex_rd;
        hit2  = id_uses_rs2 && id_rs2 == ex_rd;
        lu    = ex_use_mem && ex_write_reg && ex_rd != 0 && (hit1 || hit2);
        redir = ex_trap || pc_load;
        {e_sif, e_sid, e_sex, e_fifid, e_fidex, e_fexmem, e_start, e_abort} = '0;
        n_busy = m_busy; n_cycles = m_cycles; n_to = m_to;
        if (!m_busy) begin
            if (redir) begin
                e_fifid = 1; e_fidex = 1;
            end else if (ex_is_mc) begin
                e_start = 1; e_sif = 1; e_sid = 1; e_sex = 1; e_fexmem = 1;
                n_busy = 1; n_cycles = 0;
            end else if (lu) begin
                e_sif = 1; e_sid = 1; e_fidex = 1;
            end
        end else begin
            expired = (m_cycles + 1 == MC_TIMEOUT);
            if (ex_trap) begin
                e_abort = 1; e_fifid = 1; e_fidex = 1; n_busy = 0;
            end else if (mc_done) begin
                n_busy = 0;
                if (pc_load) begin e_fifid = 1; e_fidex = 1; end
            end else if (expired) begin
                e_abort = 1; e_fexmem = 1; n_to = 1; n_busy = 0;
                if (pc_load) begin e_fifid = 1; e_fidex = 1; end
            end else begin
                e_fexmem = 1; n_cycles = m_cycles + 1;
                if (pc_load) begin e_fifid = 1; e_fidex = 1; end
                else begin e_sif = 1; e_sid = 1; e_sex = 1; end
            end
        end
    endtask

    task automatic settle_check();
        #2;
        model_eval();
        chk("use_ex_mem_rs1", 32'(use_ex_mem_rs1), 32'(e_fm1));
        chk("use_ex_mem_rs2", 32'(use_ex_mem_rs2), 32'(e_fm2));
        chk("use_mem_wb_rs1", 32'(use_mem_wb_rs1), 32'(e_fw1));
        chk("use_mem_wb_rs2", 32'(use_mem_wb_rs2), 32'(e_fw2));
        chk("stall_if", 32'(stall_if), 32'(e_sif));
        chk("stall_id", 32'(stall_id), 32'(e_sid));
        chk("stall_ex", 32'(stall_ex), 32'(e_sex));
        chk("flush_if_id", 32'(flush_if_id), 32'(e_fifid));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(e_fidex));
        chk("flush_ex_mem", 32'(flush_ex_mem), 32'(e_fexmem));
        chk("mc_start", 32'(mc_start), 32'(e_start));
        chk("mc_abort", 32'(mc_abort), 32'(e_abort));
        chk("mc_timeout", 32'(mc_timeout), 32'(m_to));
        chk("stall_count", 32'(stall_count), 32'(m_stalls));
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_sif && m_stalls < SAT) m_stalls++;
        m_busy = n_busy; m_cycles = n_cycles; m_to = n_to;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fwd"}, 32'({use_ex_mem_rs1, use_ex_mem_rs2, use_mem_wb_rs1, use_mem_wb_rs2}), 32'd0);
        chk({tag, "_stall"}, 32'({stall_if, stall_id, stall_ex}), 32'd0);
        chk({tag, "_flush"}, 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'd0);
        chk({tag, "_mc"}, 32'({mc_start, mc_abort, mc_timeout}), 32'd0);
        chk({tag, "_count"}, 32'(stall_count), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        #1;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        settle_check(); advance();

        // Forwarding priority and x0
        mem_rd = 5; wb_rd = 5; ex_rs1 = 5; mem_write_reg = 1; wb_write_reg = 1;
        settle_check();
        chk("fwd_both_exmem", 32'(use_ex_mem_rs1), 32'd1);
        chk("fwd_both_memwb", 32'(use_mem_wb_rs1), 32'd0);
        advance();
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
        settle_check();
        chk("fwd_x0", 32'({use_ex_mem_rs1, use_mem_wb_rs1}), 32'd0);
        advance();
        clear_inputs();

        // Load-use: exactly one bubble, then the load forwards from MEM/WB
        ex_use_mem = 1; ex_write_reg = 1; ex_rd = 3; id_uses_rs1 = 1; id_rs1 = 3;
        settle_check();
        chk("lu_stall", 32'({stall_if, stall_id, flush_id_ex}), 32'h7);
        advance();
        clear_inputs();
        ex_rs1 = 3; wb_rd = 3; wb_write_reg = 1;
        settle_check();
        chk("lu_after_stall", 32'(stall_if), 32'd0);
        chk("lu_after_fwd", 32'(use_mem_wb_rs1), 32'd1);
        advance();

        // Divide: done after five stalled BUSY cycles
        do_reset();
        ex_is_mc = 1;
        settle_check();
        chk("div_start", 32'(mc_start), 32'd1);
        advance();
        ex_is_mc = 0;
        for (int i = 0; i < 5; i++) begin
            settle_check();
            chk("div_busy", 32'({mc_start, stall_if}), 32'd1);
            advance();
        end
        mc_done = 1;
        settle_check();
        chk("div_done_nostall", 32'(stall_if), 32'd0);
        advance();
        mc_done = 0;
        settle_check();
        chk("div_stall_count", 32'(stall_count), 32'd6);
        advance();

        // Watchdog
        ex_is_mc = 1;
        settle_check(); advance();
        ex_is_mc = 0;
        for (int i = 0; i < 7; i++) begin
            settle_check();
            chk("wd_no_abort", 32'(mc_abort), 32'd0);
            advance();
        end
        settle_check();
        chk("wd_abort", 32'({mc_abort, stall_if, flush_ex_mem}), 32'h5);
        chk("wd_flag_before", 32'(mc_timeout), 32'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("wd_sticky", 32'(mc_timeout), 32'd1);
            advance();
        end

        // Trap during BUSY
        ex_is_mc = 1;
        settle_check(); advance();
        ex_is_mc = 0;
        settle_check(); advance();
        ex_trap = 1;
        settle_check();
        chk("trap_busy", 32'({mc_abort, flush_if_id, flush_id_ex, stall_if}), 32'hE);
        advance();
        ex_trap = 0;
        settle_check();
        chk("trap_idle_after", 32'({stall_if, mc_start, mc_abort}), 32'd0);
        advance();

        // Taken branch beats a load-use hit
        ex_use_mem = 1; ex_write_reg = 1; ex_rd = 7; id_uses_rs2 = 1; id_rs2 = 7; pc_load = 1;
        settle_check();
        chk("br_lu_flush", 32'({flush_if_id, flush_id_ex}), 32'h3);
        chk("br_lu_stall", 32'({stall_if, stall_id}), 32'd0);
        advance();
        clear_inputs();

        // Reset asserted mid-BUSY with hazards present on the inputs
        ex_is_mc = 1;
        settle_check(); advance();
        settle_check(); advance();
        mem_rd = 4; ex_rs2 = 4; mem_write_reg = 1; pc_load = 1;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_busy");
        @(posedge clk); #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        settle_check();
        chk("reset_busy_idle", 32'({stall_if, mc_start}), 32'd0);
        advance();

        // Random traffic; small register range to make matches frequent
        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(3, 0));
            id_rs2 = 5'($urandom_range(3, 0));
            ex_rs1 = 5'($urandom_range(3, 0));
            ex_rs2 = 5'($urandom_range(3, 0));
            ex_rd  = 5'($urandom_range(3, 0));
            mem_rd = 5'($urandom_range(3, 0));
            wb_rd  = 5'($urandom_range(3, 0));
            id_uses_rs1   = 1'($urandom_range(1, 0));
            id_uses_rs2   = 1'($urandom_range(1, 0));
            ex_write_reg  = 1'($urandom_range(1, 0));
            ex_use_mem    = 1'($urandom_range(1, 0));
            mem_write_reg = 1'($urandom_range(1, 0));
            wb_write_reg  = 1'($urandom_range(1, 0));
            ex_is_mc = ($urandom_range(7, 0) == 0);
            ex_trap  = ($urandom_range(24, 0) == 0);
            pc_load  = ($urandom_range(11, 0) == 0);
            mc_done  = ($urandom_range(9, 0) == 0);
            settle_check();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
